// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Byte stream from the UART receive FIFO to the CPU load path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   logic [7:0]                  data_out;
   logic                        data_out_valid;
   logic                        data_out_ready;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (
      output data_out,
      output data_out_valid,
      output fifo_count,
      input  data_out_ready
   );

   modport slave (
      input  data_out,
      input  data_out_valid,
      input  fifo_count,
      output data_out_ready
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN)
//            feeding a small byte FIFO with a ready/valid read side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           serial_in,
   uart_rx_fifo_if.master rx_if,
   output logic           framing_error,
   output logic           overrun
);
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
   localparam int PW               = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] SAMPLE_CNT = CW'(SYMBOL_EDGE_TIME / 2);
   localparam logic [CW-1:0] LAST_CNT   = CW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY     = 3'd4;
   localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
   localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

   logic          r_rx_meta, r_rx;
   logic [2:0]    r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          w_sample, w_stop_ok, w_push_req, w_frame_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx      <= 1'b1;
      end else begin
         r_rx_meta <= serial_in;
         r_rx      <= r_rx_meta;
      end
   end

   assign w_sample = (r_bit_cnt == SAMPLE_CNT);

   // The bit counter free-runs from the start edge, so every later mid-bit
   // lands one full symbol after the previous one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (r_state == ST_IDLE) begin
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         if (!r_rx) r_state <= ST_START;
      end else begin
         r_bit_cnt <= (r_bit_cnt == LAST_CNT) ? '0 : r_bit_cnt + CW'(1);
         if (w_sample) begin
            case (r_state)
               ST_START: r_state <= r_rx ? ST_IDLE : ST_DATA;
               ST_DATA: begin
                  r_shift   <= {r_rx, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_state <= ST_AFTER_DATA;
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: r_state <= ST_STOP;
`endif
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parity_bad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_parity_bad <= 1'b0;
      else if (r_state == ST_PARITY && w_sample)
         r_parity_bad <= ^{r_shift, r_rx};
   end

   assign w_stop_ok = r_rx && !r_parity_bad;
`else
   assign w_stop_ok = r_rx;
`endif

   assign w_push_req  = (r_state == ST_STOP) && w_sample && w_stop_ok;
   assign w_frame_err = (r_state == ST_STOP) && w_sample && !w_stop_ok;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_head_ptr;
   logic [PW:0]   r_count, w_next_count;
   logic [7:0]    r_data_out, w_head_data;
   logic          w_empty, w_full, w_pop, w_push;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == FULL_CNT);
   assign w_pop        = rx_if.data_out_ready && !w_empty;
   assign w_push       = w_push_req && (!w_full || w_pop);
   assign w_next_count = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
   assign w_head_ptr   = r_rd_ptr + PW'(w_pop);
   // Head slot equals the write slot only when the FIFO drains to the byte being pushed.
   assign w_head_data  = (w_push && (w_head_ptr == r_wr_ptr)) ? r_shift : r_mem[w_head_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_shift;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_data_out    <= '0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= w_next_count;
         if (w_next_count != '0) r_data_out <= w_head_data;
         framing_error <= w_frame_err;
         overrun       <= w_push_req && !w_push;
      end
   end

   assign rx_if.data_out       = r_data_out;
   assign rx_if.data_out_valid = !w_empty;
   assign rx_if.fifo_count     = r_count;
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed bench for uart_rx_fifo: frame table plus hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;
   localparam int CLOCK_FREQ = 50_000_000;
   localparam int BAUD_RATE  = 115_200;
   localparam int FIFO_DEPTH = 8;
   localparam int BIT_CYC    = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Posedges from the start-bit negedge to the edge acting on the stop sample.
   localparam int STOP_EDGE = 3 + BIT_CYC / 2 + BIT_CYC * (FRAME_BITS - 1) + 1;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_push;
      int         exp_fe;
   } vec_t;

   logic clk;
   logic rst;
   logic serial_in;
   logic framing_error;
   logic overrun;

   int n_checks = 0;
   int n_errors = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int both_cnt = 0;

   uart_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) u_if ();

   uart_rx_fifo #(
      .CLOCK_FREQ(CLOCK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .rx_if        (u_if),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (framing_error && overrun) both_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      @(negedge clk);
      for (int b = 0; b < n; b++) begin
         serial_in = bits[b];
         repeat (BIT_CYC) @(negedge clk);
      end
      serial_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
      send_bits({stop_bit, ^data, data, 1'b0}, 11);
`else
      send_bits({1'b1, stop_bit, data, 1'b0}, 10);
`endif
   endtask

   task automatic pop_one;
      @(negedge clk);
      u_if.data_out_ready = 1'b1;
      @(negedge clk);
      u_if.data_out_ready = 1'b0;
   endtask

   initial begin
      vec_t vecs[4];
      int   fe0, ov0;
      logic [7:0] exp_b;

      vecs[0] = '{8'hC3, 1'b1, 1'b1, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1};
      vecs[2] = '{8'h5A, 1'b1, 1'b1, 0};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};

      serial_in           = 1'b1;
      u_if.data_out_ready = 1'b0;
      rst                 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  32'(u_if.data_out), 32'h0);
      check("rst_valid", 32'(u_if.data_out_valid), 32'h0);
      check("rst_count", 32'(u_if.fifo_count), 32'h0);
      check("rst_fe",    32'(framing_error), 32'h0);
      check("rst_ov",    32'(overrun), 32'h0);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // First byte: exact one-cycle latency after the stop sample.
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(negedge clk);
            repeat (STOP_EDGE - 1) @(posedge clk);
            #1;
            check("a5_valid_early", 32'(u_if.data_out_valid), 32'h0);
            @(posedge clk);
            #1;
            check("a5_valid", 32'(u_if.data_out_valid), 32'h1);
            check("a5_data",  32'(u_if.data_out), 32'hA5);
            check("a5_count", 32'(u_if.fifo_count), 32'h1);
         end
      join
      pop_one();
      check("a5_pop_count", 32'(u_if.fifo_count), 32'h0);
      check("a5_pop_valid", 32'(u_if.data_out_valid), 32'h0);
      check("a5_hold_data", 32'(u_if.data_out), 32'hA5);

      fe0 = fe_cnt;
      @(negedge clk);
      serial_in = 1'b0;
      repeat (100) @(negedge clk);
      serial_in = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
      check("glitch_count", 32'(u_if.fifo_count), 32'h0);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'h0);

      for (int i = 0; i < 4; i++) begin
         fe0 = fe_cnt;
         send_frame(vecs[i].data, vecs[i].stop);
         repeat (4) @(negedge clk);
         check($sformatf("vec%0d_count", i), 32'(u_if.fifo_count), vecs[i].exp_push ? 32'h1 : 32'h0);
         check($sformatf("vec%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
         if (vecs[i].exp_push) begin
            check($sformatf("vec%0d_data", i), 32'(u_if.data_out), 32'(vecs[i].data));
            pop_one();
            check($sformatf("vec%0d_popped", i), 32'(u_if.fifo_count), 32'h0);
         end
      end

      ov0 = ov_cnt;
      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
      repeat (4) @(negedge clk);
      check("burst_full_count", 32'(u_if.fifo_count), 32'h8);
      check("burst_no_ov_yet", 32'(ov_cnt - ov0), 32'h0);
      send_frame(8'h08, 1'b1);
      repeat (4) @(negedge clk);
      check("burst_ov_count", 32'(u_if.fifo_count), 32'h8);
      check("burst_ov_once", 32'(ov_cnt - ov0), 32'h1);
      check("burst_head", 32'(u_if.data_out), 32'h00);

      // Pop lands on the same edge as the push of a byte arriving into a full FIFO.
      fork
         send_frame(8'h09, 1'b1);
         begin
            @(negedge clk);
            repeat (STOP_EDGE - 1) @(posedge clk);
            @(negedge clk);
            u_if.data_out_ready = 1'b1;
            @(negedge clk);
            u_if.data_out_ready = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("full_pp_count", 32'(u_if.fifo_count), 32'h8);
      check("full_pp_no_ov", 32'(ov_cnt - ov0), 32'h1);
      for (int i = 0; i < 8; i++) begin
         exp_b = (i < 7) ? 8'(i + 1) : 8'h09;
         check($sformatf("drain%0d_valid", i), 32'(u_if.data_out_valid), 32'h1);
         check($sformatf("drain%0d_data", i), 32'(u_if.data_out), 32'(exp_b));
         pop_one();
      end
      check("drain_valid", 32'(u_if.data_out_valid), 32'h0);
      check("drain_count", 32'(u_if.fifo_count), 32'h0);
      pop_one();
      check("underflow_count", 32'(u_if.fifo_count), 32'h0);
      check("underflow_valid", 32'(u_if.data_out_valid), 32'h0);

      send_frame(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      check("pre_rst_count", 32'(u_if.fifo_count), 32'h1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (BIT_CYC * 4) @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check("midrst_data",  32'(u_if.data_out), 32'h0);
            check("midrst_valid", 32'(u_if.data_out_valid), 32'h0);
            check("midrst_count", 32'(u_if.fifo_count), 32'h0);
            check("midrst_fe",    32'(framing_error), 32'h0);
            check("midrst_ov",    32'(overrun), 32'h0);
            rst = 1'b1;
         end
      join
      repeat (10) @(negedge clk);
      check("post_rst_count", 32'(u_if.fifo_count), 32'h0);
      send_frame(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      check("post_rst_rx_count", 32'(u_if.fifo_count), 32'h1);
      check("post_rst_rx_data", 32'(u_if.data_out), 32'h81);
      pop_one();

`ifdef UART_RX_PARITY_EN
      fe0 = fe_cnt;
      send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
      repeat (4) @(negedge clk);
      check("par_bad_count", 32'(u_if.fifo_count), 32'h0);
      check("par_bad_fe", 32'(fe_cnt - fe0), 32'h1);
      send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
      repeat (4) @(negedge clk);
      check("par_ok_count", 32'(u_if.fifo_count), 32'h1);
      check("par_ok_data", 32'(u_if.data_out), 32'h07);
      check("par_ok_fe", 32'(fe_cnt - fe0), 32'h1);
      pop_one();
`endif

      check("fe_ov_overlap", 32'(both_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
